// File: rtl/sb_msg_pkg.sv
// Shared definitions for the LTSM sideband message path: opcode, LTSM state
// codes, per-state message indices, msgcode/subcode pairs and the table lookup.
package sb_msg_pkg;

  localparam int LTSM_STATE_W = 4;
  localparam int SB_MSG_W     = 4;

  localparam logic [4:0] OPC_MSG_NODATA = 5'b10010;

  typedef enum logic [LTSM_STATE_W-1:0] {
    ST_RESET      = 4'h0,
    ST_SBINIT     = 4'h1,
    ST_MBINIT     = 4'h2,
    ST_MBTRAIN    = 4'h3,
    ST_LINKINIT   = 4'h4,
    ST_ACTIVE     = 4'h5,
    ST_TRAINERROR = 4'hF
  } ltsm_state_e;

  // Message indices are local to each state; index 0 always means "no message".
  typedef enum logic [SB_MSG_W-1:0] {
    SBINIT_MSG_OUT_OF_RESET = 4'd1,
    SBINIT_MSG_DONE_REQ     = 4'd2,
    SBINIT_MSG_DONE_RESP    = 4'd3
  } sbinit_msg_e;

  typedef enum logic [SB_MSG_W-1:0] {
    MBINIT_MSG_PARAM_CFG_REQ  = 4'd1,
    MBINIT_MSG_PARAM_CFG_RESP = 4'd2
  } mbinit_msg_e;

  typedef enum logic [SB_MSG_W-1:0] {
    TRAINERROR_MSG_ENTRY_REQ  = 4'd1,
    TRAINERROR_MSG_ENTRY_RESP = 4'd2
  } trainerror_msg_e;

  // {msgcode, msgsubcode}
  localparam logic [15:0] MC_SBINIT_OUT_OF_RESET    = {8'h91, 8'h00};
  localparam logic [15:0] MC_SBINIT_DONE_REQ        = {8'h95, 8'h01};
  localparam logic [15:0] MC_SBINIT_DONE_RESP       = {8'h9A, 8'h01};
  localparam logic [15:0] MC_MBINIT_PARAM_CFG_REQ   = {8'hA5, 8'h00};
  localparam logic [15:0] MC_MBINIT_PARAM_CFG_RESP  = {8'hAA, 8'h00};
  localparam logic [15:0] MC_TRAINERROR_ENTRY_REQ   = {8'hE5, 8'h00};
  localparam logic [15:0] MC_TRAINERROR_ENTRY_RESP  = {8'hE6, 8'h00};

  typedef struct packed {
    logic       hit;
    logic [7:0] msgcode;
    logic [7:0] subcode;
  } msg_lookup_t;

  // Maps a {state, message index} pair to its header codes; hit=0 if unmapped.
  function automatic msg_lookup_t msg_lookup(input logic [LTSM_STATE_W-1:0] state,
                                             input logic [SB_MSG_W-1:0]     msg);
    msg_lookup_t r;
    logic [15:0] code;
    logic        hit;
    hit  = 1'b1;
    code = '0;
    case (state)
      ST_SBINIT: begin
        case (msg)
          SBINIT_MSG_OUT_OF_RESET: code = MC_SBINIT_OUT_OF_RESET;
          SBINIT_MSG_DONE_REQ:     code = MC_SBINIT_DONE_REQ;
          SBINIT_MSG_DONE_RESP:    code = MC_SBINIT_DONE_RESP;
          default:                 hit  = 1'b0;
        endcase
      end
      ST_MBINIT: begin
        case (msg)
          MBINIT_MSG_PARAM_CFG_REQ:  code = MC_MBINIT_PARAM_CFG_REQ;
          MBINIT_MSG_PARAM_CFG_RESP: code = MC_MBINIT_PARAM_CFG_RESP;
          default:                   hit  = 1'b0;
        endcase
      end
      ST_TRAINERROR: begin
        case (msg)
          TRAINERROR_MSG_ENTRY_REQ:  code = MC_TRAINERROR_ENTRY_REQ;
          TRAINERROR_MSG_ENTRY_RESP: code = MC_TRAINERROR_ENTRY_RESP;
          default:                   hit  = 1'b0;
        endcase
      end
      default: hit = 1'b0;
    endcase
    r.hit     = hit;
    r.msgcode = code[15:8];
    r.subcode = code[7:0];
    return r;
  endfunction

endpackage

// File: rtl/sb_header_builder.sv
// Combinational builder of the 64-bit "message without data" header.
// SB_PARITY_EN: when defined, cp (bit 62) is the XOR of header bits [61:0];
// otherwise cp is tied to 0.
module sb_header_builder
  import sb_msg_pkg::*;
(
  input  logic [7:0]  i_msgcode,
  input  logic [7:0]  i_subcode,
  input  logic [2:0]  i_srcid,
  input  logic [2:0]  i_dstid,
  output logic [63:0] o_header
);

  logic [31:0] phase0;
  logic [61:0] low_bits;
  logic        cp;

  assign phase0   = {i_srcid, 7'b0, i_msgcode, 9'b0, OPC_MSG_NODATA};
  assign low_bits = {3'b0, i_dstid, 16'b0, i_subcode, phase0};

`ifdef SB_PARITY_EN
  assign cp = ^low_bits;
`else
  assign cp = 1'b0;
`endif

  // dp is always 0: this header never carries a data payload.
  assign o_header = {1'b0, cp, low_bits};

endmodule

// File: rtl/sb_ltsm_msg_packetizer.sv
// LTSM-to-sideband message packetizer: accepts a {state, msg} request, builds
// the header, shifts it out LSB-first, then holds the line idle for GAP_UI.
// SB_PARITY_EN selects whether the header control parity bit is computed.
module sb_ltsm_msg_packetizer
  import sb_msg_pkg::*;
#(
  parameter int          SB_MSG_WIDTH = 4,
  parameter int          STATE_W      = 4,
  parameter int          PKT_W        = 64,
  parameter int          GAP_UI       = 32,
  parameter logic [2:0]  SRCID        = 3'b001,
  parameter logic [2:0]  DSTID        = 3'b101
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_tx_msg_valid,
  input  logic [SB_MSG_WIDTH-1:0] i_encoded_SB_msg,
  input  logic [STATE_W-1:0]      i_ltsm_state,
  output logic                    o_SB_Busy,
  output logic                    o_falling_edge_busy,
  output logic                    o_sb_data,
  output logic                    o_sb_clk_en,
  output logic                    o_msg_err
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} fsm_e;

  fsm_e                    state_q, state_d;
  logic [6:0]              cnt_q, cnt_d;
  logic [PKT_W-1:0]        hdr_q, hdr_d;
  logic [STATE_W-1:0]      st_q, st_d;
  logic [SB_MSG_WIDTH-1:0] msg_q, msg_d;
  logic                    busy_q, busy_d;
  logic                    fall_q, fall_d;
  logic                    data_q, data_d;
  logic                    clken_q, clken_d;
  logic                    err_q, err_d;

  logic [STATE_W-1:0]      lu_state;
  logic [SB_MSG_WIDTH-1:0] lu_msg;
  msg_lookup_t             lu;
  logic [63:0]             hdr_built;

  // One shared table lookup: the live request while idle, the latched pair otherwise.
  always_comb begin
    lu_state = (state_q == S_IDLE) ? i_ltsm_state     : st_q;
    lu_msg   = (state_q == S_IDLE) ? i_encoded_SB_msg : msg_q;
    lu       = msg_lookup(lu_state, lu_msg);
  end

  sb_header_builder u_hdr (
    .i_msgcode (lu.msgcode),
    .i_subcode (lu.subcode),
    .i_srcid   (SRCID),
    .i_dstid   (DSTID),
    .o_header  (hdr_built)
  );

  // State, counter, header and all outputs are registered here.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hdr_q   <= '0;
      st_q    <= '0;
      msg_q   <= '0;
      busy_q  <= 1'b0;
      fall_q  <= 1'b0;
      data_q  <= 1'b0;
      clken_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hdr_q   <= hdr_d;
      st_q    <= st_d;
      msg_q   <= msg_d;
      busy_q  <= busy_d;
      fall_q  <= fall_d;
      data_q  <= data_d;
      clken_q <= clken_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; output registers are loaded one cycle ahead so that
  // while in SHIFT with counter k the line carries header bit k.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 7'd1;
    hdr_d   = hdr_q;
    st_d    = st_q;
    msg_d   = msg_q;
    busy_d  = busy_q;
    fall_d  = 1'b0;
    data_d  = 1'b0;
    clken_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (i_tx_msg_valid && !busy_q && (i_encoded_SB_msg != '0)) begin
          if (lu.hit) begin
            st_d    = i_ltsm_state;
            msg_d   = i_encoded_SB_msg;
            busy_d  = 1'b1;
            state_d = S_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        hdr_d   = hdr_built;
        data_d  = hdr_built[0];
        clken_d = 1'b1;
        cnt_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (cnt_q == 7'(PKT_W - 1)) begin
          hdr_d   = '0;
          cnt_d   = '0;
          state_d = S_GAP;
        end else begin
          hdr_d   = hdr_q >> 1;
          data_d  = hdr_q[1];
          clken_d = 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == 7'(GAP_UI - 1)) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          fall_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign o_SB_Busy           = busy_q;
  assign o_falling_edge_busy = fall_q;
  assign o_sb_data           = data_q;
  assign o_sb_clk_en         = clken_q;
  assign o_msg_err           = err_q;

endmodule
